cache_mem_arbiter: RTL and testbench

//  Arbitrates the I-cache (read-only) and D-cache (read/write-back) line ports onto
//  the single line-granular port of the burst cache adapter, which feeds bmem.

---
 rtl/cache_mem_arb_pkg.sv | 27 ++
 rtl/cache_mem_arbiter_arb_pick2.sv | 38 +++
 rtl/cache_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the I/D cache line arbiter in front of the burst cache adapter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, requester enum, operation enum, line offset width.
package cache_mem_arb_pkg;

  // Byte-offset bits inside a 32-byte (256-bit) line; forced to zero on mem_addr.
  localparam int LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } req_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/cache_mem_arbiter_arb_pick2.sv
// Combinational 2-way picker between I-cache and D-cache line requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
//
// Build option: ARB_RR_EN selects round-robin on a tie (the port not in
// last_grant_i wins); otherwise D-cache has fixed priority over I-cache.
// Ports: i_req_i / d_req_i  request flags
//        last_grant_i       previous winner (round-robin build only)
//        vld_o / grant_o    any request present / chosen requester
module arb_pick2
  import cache_mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
`ifdef ARB_RR_EN
  input  req_e last_grant_i,
`endif
  output logic vld_o,
  output req_e grant_o
);

  always_comb begin
    vld_o   = i_req_i | d_req_i;
    grant_o = DCACHE;
`ifdef ARB_RR_EN
    if (i_req_i && d_req_i) begin
      grant_o = (last_grant_i == DCACHE) ? ICACHE : DCACHE;
    end else if (i_req_i) begin
      grant_o = ICACHE;
    end
`else
    if (i_req_i && !d_req_i) begin
      grant_o = ICACHE;
    end
`endif
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache line ports onto the single burst-adapter line port.
// Latency: request sampled cycle N -> mem_* high N+1; adapter done cycle M -> resp/rdata M+1.
// Backpressure: requesters hold their request until resp; one transaction in flight at a time.
//
// Build option: ARB_RR_EN enables round-robin tie-breaking (adds last_grant register);
// default is fixed D-cache-over-I-cache priority.
// Ports: clk / rst (async, active-low)
//        i_read, i_addr -> i_rdata, i_resp                 I-cache line reads
//        d_read, d_write, d_addr, d_wdata -> d_rdata, d_resp D-cache fills / write-backs
//        mem_read, mem_write, mem_addr, mem_wdata          to burst adapter
//        mem_rdata, mem_rresp, mem_wresp                   from burst adapter
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rresp,
  input  logic              mem_wresp
);

  state_e            state_q;
  req_e              owner_q;
  op_e               op_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_resp_q;
  logic              d_resp_q;
`ifdef ARB_RR_EN
  req_e              last_grant_q;
`endif

  logic              pick_vld;
  req_e              pick_grant;
  op_e               op_d;
  logic [ADDR_W-1:0] addr_d;
  logic              txn_done;

  arb_pick2 u_pick (
    .i_req_i      (i_read),
    .d_req_i      (d_read | d_write),
`ifdef ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .vld_o        (pick_vld),
    .grant_o      (pick_grant)
  );

  // Winner's operation and line-aligned address. With both D strobes high the
  // write-back wins; the read stays pending for a later grant.
  always_comb begin
    op_d   = OP_READ;
    addr_d = {i_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    if (pick_grant == DCACHE) begin
      op_d   = d_write ? OP_WRITE : OP_READ;
      addr_d = {d_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    end
  end

  // Only the done pulse matching the in-flight operation ends it.
  assign txn_done = (op_q == OP_READ) ? mem_rresp : mem_wresp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= ICACHE;
      op_q         <= OP_READ;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= ICACHE;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q      <= pick_grant;
            op_q         <= op_d;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= (op_d == OP_WRITE) ? d_wdata : '0;
            mem_read_q   <= (op_d == OP_READ);
            mem_write_q  <= (op_d == OP_WRITE);
`ifdef ARB_RR_EN
            last_grant_q <= pick_grant;
`endif
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (txn_done) begin
            if (op_q == OP_READ) begin
              if (owner_q == ICACHE) i_rdata_q <= mem_rdata;
              else                   d_rdata_q <= mem_rdata;
            end
            i_resp_q    <= (owner_q == ICACHE);
            d_resp_q    <= (owner_q == DCACHE);
            // Dropping the strobes here guarantees the adapter one low cycle.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Requests are not sampled here, so a request still held through
          // its own resp cycle cannot launch a duplicate transaction.
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;

  // Caches must never raise both D strobes together.
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write));

  // The owner must keep its request up for the whole transaction.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == BUSY && owner_q == ICACHE) |-> i_read);
  a_d_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == BUSY && owner_q == DCACHE) |-> ((op_q == OP_WRITE) ? d_write : d_read));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops and compares.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rresp;
  logic              mem_wresp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_wresp(mem_wresp)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cyc = -10;
  int n_issued = 0;
  int n_txn = 0;

  logic [LINE_W-1:0] iq[$];
  logic [LINE_W-1:0] dq[$];
  logic [ADDR_W-1:0] order_q[$];
  logic [LINE_W-1:0] ref_mem[logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] bmem[logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ref_d_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:5], 5'b0};
  endfunction

  function automatic logic [LINE_W-1:0] default_line(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_1220) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [LINE_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_line(a);
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // I-cache requester: hold i_read until i_resp is seen, then drop.
  task automatic do_i(input logic [ADDR_W-1:0] a, input bit chk_lat);
    int t;
    i_addr = a;
    i_read = 1'b1;
    iq.push_back(ref_read(align(a)));
    n_issued++;
    if (chk_lat) begin
      @(posedge clk); #1;
      check("i_issue_mem_read", 256'(mem_read), 256'(1));
      check("i_issue_mem_addr", 256'(mem_addr), 256'(align(a)));
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!i_resp && t < 500);
    check("i_resp_seen", 256'(i_resp), 256'(1));
    i_read = 1'b0;
  endtask

  // D-cache requester; keep=1 leaves the strobe up so the next call is back-to-back.
  task automatic do_d(input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] data, input bit chk_lat, input bit keep);
    int t;
    d_addr  = a;
    d_wdata = wr ? data : '0;
    d_write = wr;
    d_read  = !wr;
    if (wr) ref_mem[align(a)] = data;
    else    ref_d_last = ref_read(align(a));
    dq.push_back(ref_d_last);
    n_issued++;
    if (chk_lat) begin
      @(posedge clk); #1;
      check("d_issue_mem_write", 256'(mem_write), 256'(wr));
      check("d_issue_mem_addr", 256'(mem_addr), 256'(align(a)));
      check("d_issue_mem_wdata", mem_wdata, wr ? data : '0);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!d_resp && t < 500);
    check("d_resp_seen", 256'(d_resp), 256'(1));
    if (!keep) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  // Adapter + bmem model: random latency, stray opposite-type done pulses, garbage rdata.
  initial begin
    int cnt;
    bit busy, is_wr, stray;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] wd;
    mem_rresp = 1'b0; mem_wresp = 1'b0; mem_rdata = '0;
    busy = 0; stray = 0; is_wr = 0; cnt = 0; a = '0; wd = '0;
    forever begin
      @(posedge clk); #1;
      mem_rresp = 1'b0;
      mem_wresp = 1'b0;
      mem_rdata = {8{$urandom}};
      if (!rst) begin
        busy = 0; stray = 0;
      end else if (!busy) begin
        if (mem_read || mem_write) begin
          busy = 1; is_wr = mem_write; a = mem_addr; wd = mem_wdata;
          cnt = $urandom_range(0, 5);
        end
      end else begin
        if (stray) begin
          check("stray_pulse_ignored", 256'(mem_read | mem_write), 256'(1));
          stray = 0;
        end
        if (cnt == 0) begin
          if (is_wr) begin
            check("mem_wdata_stable", mem_wdata, wd);
            bmem[a] = mem_wdata;
            mem_wresp = 1'b1;
          end else begin
            mem_rdata = bmem.exists(a) ? bmem[a] : default_line(a);
            mem_rresp = 1'b1;
          end
          busy = 0;
        end else begin
          cnt--;
          if ($urandom_range(0, 2) == 0) begin
            stray = 1;
            if (is_wr) mem_rresp = 1'b1;
            else       mem_wresp = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: transaction starts, response latency and response data.
  initial begin
    logic act, prev_act;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      act = mem_read | mem_write;
      if (!rst) begin
        prev_act = 1'b0;
      end else begin
        if ((mem_read && mem_rresp) || (mem_write && mem_wresp)) done_cyc = cyc;
        if (act && !prev_act) begin
          n_txn++;
          check("txn_single_op", 256'(mem_read & mem_write), 256'(0));
          check("txn_addr_aligned", 256'(mem_addr[4:0]), 256'(0));
          if (order_q.size() > 0) check("txn_order", 256'(mem_addr), 256'(order_q.pop_front()));
        end
        prev_act = act;
        if (i_resp || d_resp) begin
          check("resp_exclusive", 256'(i_resp & d_resp), 256'(0));
          check("resp_latency", 256'(cyc), 256'(done_cyc + 1));
        end
        if (i_resp) begin
          if (iq.size() == 0) check("i_resp_expected", 256'(1), 256'(0));
          else check("i_rdata", i_rdata, iq.pop_front());
        end
        if (d_resp) begin
          if (dq.size() == 0) check("d_resp_expected", 256'(1), 256'(0));
          else check("d_rdata", d_rdata, dq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    int t;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_read", 256'(mem_read), 256'(0));
    check("rst_mem_write", 256'(mem_write), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_resp", 256'({i_resp, d_resp}), 256'(0));
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;

    // Lone I-cache read with byte offset.
    @(posedge clk); #1;
    do_i(32'h0000_1234, 1);

    // Lone D-cache write-back; d_rdata must stay at its last value.
    @(posedge clk); #1;
    do_d(1, 32'h0000_0040, {2{128'h00112233445566778899AABBCCDDEEFF}}, 1, 0);

    // Read the written line back through the D port.
    @(posedge clk); #1;
    do_d(0, 32'h0000_004C, '0, 0, 0);

    // Simultaneous requests after a D grant.
    @(posedge clk); #1;
    do_d(0, 32'h0002_0100, '0, 0, 0);
    @(posedge clk); #1;
`ifdef ARB_RR_EN
    order_q.push_back(32'h0001_0040);
    order_q.push_back(32'h0002_0200);
`else
    order_q.push_back(32'h0002_0200);
    order_q.push_back(32'h0001_0040);
`endif
    fork
      do_i(32'h0001_0048, 0);
      do_d(0, 32'h0002_0200, '0, 0, 0);
    join
    check("order_q_drained", 256'(order_q.size()), 256'(0));

    // Back-to-back D reads with the strobe held through the resp cycle.
    @(posedge clk); #1;
    do_d(0, 32'h0002_0300, '0, 0, 1);
    do_d(0, 32'h0002_0320, '0, 0, 0);

    // Reset in the middle of a read transaction.
    @(posedge clk); #1;
    i_addr = 32'h0001_0080;
    i_read = 1'b1;
    n_issued++;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_read && t < 50);
    check("abort_txn_started", 256'(mem_read), 256'(1));
    #2 rst = 1'b0;
    #1;
    check("abort_mem_strobes", 256'({mem_read, mem_write}), 256'(0));
    check("abort_mem_addr", 256'(mem_addr), 256'(0));
    check("abort_resp", 256'({i_resp, d_resp}), 256'(0));
    check("abort_i_rdata", i_rdata, '0);
    check("abort_d_rdata", d_rdata, '0);
    i_read = 1'b0;
    ref_d_last = '0;
    repeat (2) @(negedge clk);
    check("abort_no_resp", 256'({i_resp, d_resp}), 256'(0));
    rst = 1'b1;

    // Fresh read after reset release.
    @(posedge clk); #1;
    do_i(32'h0001_0090, 1);

    // Randomised concurrent traffic; I and D use disjoint address regions.
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_i(32'h0001_0000 | 32'($urandom_range(0, 7) << 5) | 32'($urandom_range(0, 31)), 0);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          do_d($urandom_range(0, 1) == 1,
               32'h0002_0000 | 32'($urandom_range(0, 7) << 5) | 32'($urandom_range(0, 31)),
               {8{$urandom}}, 0, 0);
        end
      end
    join

    repeat (4) @(negedge clk);
    check("txn_count", 256'(n_txn), 256'(n_issued));
    check("iq_drained", 256'(iq.size()), 256'(0));
    check("dq_drained", 256'(dq.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
